// File: rtl/chu_stepper.sv
// Step/direction pulse generator on one FPro MMIO slot: evenly spaced step pulses,
// signed position tracking, busy/remaining/overrun status readback.
module chu_stepper #(
   parameter int unsigned W         = 24,
   parameter int unsigned PULSE_W   = 100,
   parameter int unsigned SETUP_CYC = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   output logic [31:0] rd_data,
   input  logic [31:0] wr_data,
   output logic        step,
   output logic        dir,
   output logic        en
);

   localparam logic [W-1:0] MinPer    = W'(PULSE_W + 1);
   localparam logic [W-1:0] HighLast  = W'(PULSE_W - 1);
   localparam logic [W-1:0] SetupLast = W'(SETUP_CYC);

   typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_e;

   state_e        state_q, state_d;
   logic          en_q, en_d;
   logic          dir_q, dir_d;
   logic          ovr_q, ovr_d;
   logic          stop_pend_q, stop_pend_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]  per_q, per_d;
   logic [W-1:0]  period_q, period_d;
   logic [31:0]   pos_q, pos_d;

   logic          wr_en;
   logic          ctrl_wr, period_wr, move_wr, stop_wr, clr_wr;
   logic          busy, stop_req, gap_done, finish, accept_win, move_ok, enter_high;
   logic [W-1:0]  move_cnt;

   // read strobe has no side effects; upper write bits are reserved
   logic          unused_in;
   assign unused_in = read ^ (^wr_data[30:W]);

   assign wr_en     = cs & write;
   assign ctrl_wr   = wr_en && (addr == 5'd0);
   assign period_wr = wr_en && (addr == 5'd1);
   assign move_wr   = wr_en && (addr == 5'd2);
   assign stop_wr   = wr_en && (addr == 5'd3);
   assign clr_wr    = wr_en && (addr == 5'd4);
   assign move_cnt  = wr_data[W-1:0];

   assign busy     = (state_q != StIdle);
   // Dropping enable mid-move is treated as a STOP
   assign stop_req = stop_wr | (ctrl_wr & ~wr_data[0] & busy);
   assign gap_done = (state_q == StLow) && (cnt_q == per_q - W'(1));
   assign finish   = gap_done && ((rem_q == '0) || stop_pend_q || stop_req);
   // The edge that ends a move also accepts a new MOVE
   assign accept_win = !busy || finish;
   assign move_ok    = move_wr && accept_win && en_q && (move_cnt != '0);

   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      dir_d       = dir_q;
      ovr_d       = ovr_q;
      stop_pend_d = stop_pend_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      per_d       = per_q;
      period_d    = period_q;
      pos_d       = pos_q;
      enter_high  = 1'b0;

      case (state_q)
         StSetup: begin
            if (stop_req) begin
               state_d = StIdle;
            end else if (cnt_q == SetupLast) begin
               state_d    = StHigh;
               enter_high = 1'b1;
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end
         StHigh: begin
            cnt_d = cnt_q + W'(1);
            if (cnt_q == HighLast) begin
               state_d = StLow;
            end
         end
         StLow: begin
            cnt_d = cnt_q + W'(1);
            if (finish) begin
               state_d = StIdle;
            end else if (gap_done) begin
               state_d    = StHigh;
               enter_high = 1'b1;
            end
         end
         default: ;
      endcase

      if (move_ok) begin
         state_d = StSetup;
         cnt_d   = '0;
         rem_d   = move_cnt;
         dir_d   = wr_data[31];
      end

      if (enter_high) begin
         cnt_d = '0;
         rem_d = rem_q - W'(1);
         per_d = (period_q > MinPer) ? period_q : MinPer;
         pos_d = dir_q ? pos_q - 32'd1 : pos_q + 32'd1;
      end

      if (stop_req) begin
         rem_d = '0;
      end

      if ((state_d == StIdle) || move_ok) begin
         stop_pend_d = 1'b0;
      end else if (stop_req) begin
         stop_pend_d = 1'b1;
      end

      if (stop_req) begin
         ovr_d = 1'b0;
      end else if (move_wr && !accept_win) begin
         ovr_d = 1'b1;
      end

      if (ctrl_wr) begin
         en_d = wr_data[0];
      end
      if (period_wr) begin
         period_d = wr_data[W-1:0];
      end
      // A coincident clear beats the step's position update
      if (clr_wr) begin
         pos_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         en_q        <= 1'b0;
         dir_q       <= 1'b0;
         ovr_q       <= 1'b0;
         stop_pend_q <= 1'b0;
         rem_q       <= '0;
         cnt_q       <= '0;
         per_q       <= '0;
         period_q    <= '0;
         pos_q       <= '0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         dir_q       <= dir_d;
         ovr_q       <= ovr_d;
         stop_pend_q <= stop_pend_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         per_q       <= per_d;
         period_q    <= period_d;
         pos_q       <= pos_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         5'd0: begin
            rd_data[W-1:0] = rem_q;
            rd_data[30]    = ovr_q;
            rd_data[31]    = busy;
         end
         5'd1:    rd_data = pos_q;
         5'd2:    rd_data[W-1:0] = period_q;
         default: ;
      endcase
   end

   assign step = (state_q == StHigh);
   assign dir  = dir_q;
   assign en   = en_q;

endmodule

// File: tb/tb_chu_stepper.sv
// Directed bench for chu_stepper: pulse timing, position, overrun, STOP, POS_CLR, reset.
module tb_chu_stepper;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] rd_data;
   logic [31:0] wr_data;
   logic        step;
   logic        dir;
   logic        en;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rises[$];
   int falls[$];
   logic step_prev = 1'b0;

   chu_stepper #(
      .W         (24),
      .PULSE_W   (100),
      .SETUP_CYC (50)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .rd_data (rd_data),
      .wr_data (wr_data),
      .step    (step),
      .dir     (dir),
      .en      (en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Edge index of each step rise/fall, as seen on the following falling clk edge
   always @(negedge clk) begin
      if (step && !step_prev) rises.push_back(cyc);
      if (!step && step_prev) falls.push_back(cyc);
      step_prev = step;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      tick();
      cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = '0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rd_data;
      addr = 5'd0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wait_rise(input int n, input int max);
      int k;
      k = 0;
      while (rises.size() < n && k < max) begin
         tick();
         k++;
      end
      if (rises.size() < n) check_eq("rise_timeout", 32'(rises.size()), 32'(n));
   endtask

   task automatic wait_idle(input int max, output int fe);
      fe = -1;
      for (int k = 0; k < max; k++) begin
         tick();
         if (!rd_data[31]) begin
            fe = cyc;
            break;
         end
      end
      if (fe < 0) check_eq("idle_timeout", {31'b0, rd_data[31]}, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      int t0, fe, r;
      reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
      #3;
      check_eq("rst_step", {31'b0, step}, 32'd0);
      check_eq("rst_dir", {31'b0, dir}, 32'd0);
      check_eq("rst_en", {31'b0, en}, 32'd0);
      rd(5'd0, v); check_eq("rst_status", v, 32'd0);
      rd(5'd1, v); check_eq("rst_pos", v, 32'd0);
      rd(5'd2, v); check_eq("rst_period", v, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Forward move of 5
      bus_wr(5'd1, 32'd1000);
      bus_wr(5'd0, 32'd1);
      check_eq("en_on", {31'b0, en}, 32'd1);
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd5);
      t0 = cyc;
      rd(5'd0, v); check_eq("fwd_busy_rem", v, 32'h8000_0005);
      check_eq("fwd_dir", {31'b0, dir}, 32'd0);
      wait_rise(1, 100);
      rd(5'd0, v); check_eq("fwd_rem_at_rise", v, 32'h8000_0004);
      rd(5'd1, v); check_eq("fwd_pos_at_rise", v, 32'd1);
      wait_idle(6000, fe);
      check_eq("fwd_nrise", 32'(rises.size()), 32'd5);
      check_eq("fwd_first", 32'(rises[0] - t0), 32'd51);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("fwd_width%0d", i), 32'(falls[i] - rises[i]), 32'd100);
         if (i > 0) check_eq($sformatf("fwd_gap%0d", i), 32'(rises[i] - rises[i-1]), 32'd1000);
      end
      check_eq("fwd_busy_fall", 32'(fe - rises[4]), 32'd1000);
      rd(5'd1, v); check_eq("fwd_pos", v, 32'd5);
      rd(5'd0, v); check_eq("fwd_status_end", v, 32'd0);

      // Reverse 3
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'h8000_0003);
      check_eq("rev_dir", {31'b0, dir}, 32'd1);
      wait_idle(4000, fe);
      check_eq("rev_nrise", 32'(rises.size()), 32'd3);
      rd(5'd1, v); check_eq("rev_pos", v, 32'd2);

      // Period below the minimum is stretched to PULSE_W+1
      bus_wr(5'd1, 32'd10);
      rd(5'd2, v); check_eq("period_rb", v, 32'd10);
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd2);
      wait_idle(1000, fe);
      check_eq("min_nrise", 32'(rises.size()), 32'd2);
      check_eq("min_gap", 32'(rises[1] - rises[0]), 32'd101);
      check_eq("min_width", 32'(falls[1] - rises[1]), 32'd100);
      check_eq("min_busy_fall", 32'(fe - rises[1]), 32'd101);
      rd(5'd1, v); check_eq("min_pos", v, 32'd4);

      // Count 0 and disabled MOVEs are ignored
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'h8000_0000);
      rd(5'd0, v); check_eq("cnt0_idle", v, 32'd0);
      check_eq("cnt0_dir", {31'b0, dir}, 32'd0);
      bus_wr(5'd0, 32'd0);
      check_eq("en_off", {31'b0, en}, 32'd0);
      bus_wr(5'd2, 32'd3);
      rd(5'd0, v); check_eq("dis_idle", v, 32'd0);
      for (int i = 0; i < 200; i++) tick();
      check_eq("ign_nrise", 32'(rises.size()), 32'd0);
      bus_wr(5'd0, 32'd1);

      // Overrun, then a MOVE landing on the busy-fall edge
      bus_wr(5'd1, 32'd200);
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd3);
      bus_wr(5'd2, 32'd7);
      rd(5'd0, v); check_eq("ovr_status", v, 32'hC000_0003);
      wait_rise(3, 1000);
      r = rises[2];
      wait_cyc(r + 199);
      bus_wr(5'd2, 32'd1);
      rd(5'd0, v); check_eq("edge_move_taken", v, 32'hC000_0001);
      wait_idle(1000, fe);
      check_eq("ovr_nrise", 32'(rises.size()), 32'd4);
      rd(5'd0, v); check_eq("ovr_sticky", v, 32'h4000_0000);
      rd(5'd1, v); check_eq("ovr_pos", v, 32'd8);
      bus_wr(5'd3, 32'd0);
      rd(5'd0, v); check_eq("stop_idle_clr", v, 32'd0);

      // STOP 20 cycles into pulse 2 of 10
      bus_wr(5'd1, 32'd1000);
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd10);
      wait_rise(2, 2000);
      r = rises[1];
      wait_cyc(r + 19);
      bus_wr(5'd3, 32'd0);
      rd(5'd0, v); check_eq("stop_hi_status", v, 32'h8000_0000);
      wait_idle(2000, fe);
      check_eq("stop_nrise", 32'(rises.size()), 32'd2);
      check_eq("stop_width", 32'(falls[1] - rises[1]), 32'd100);
      check_eq("stop_busy_fall", 32'(fe - r), 32'd1000);
      rd(5'd1, v); check_eq("stop_pos", v, 32'd10);

      // STOP during SETUP
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd5);
      for (int i = 0; i < 10; i++) tick();
      bus_wr(5'd3, 32'd0);
      rd(5'd0, v); check_eq("stop_setup_idle", v, 32'd0);
      for (int i = 0; i < 300; i++) tick();
      check_eq("stop_setup_nrise", 32'(rises.size()), 32'd0);

      // POS_CLR on the rise edge wins
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd2);
      t0 = cyc;
      wait_cyc(t0 + 50);
      bus_wr(5'd4, 32'd0);
      check_eq("clr_rise_seen", 32'(rises.size()), 32'd1);
      rd(5'd1, v); check_eq("clr_pos", v, 32'd0);
      rd(5'd0, v); check_eq("clr_rem", v, 32'h8000_0001);
      wait_idle(3000, fe);
      rd(5'd1, v); check_eq("clr_pos_after", v, 32'd1);

      // Wrap below zero
      bus_wr(5'd4, 32'd0);
      rd(5'd1, v); check_eq("clr_idle", v, 32'd0);
      bus_wr(5'd2, 32'h8000_0001);
      wait_idle(2000, fe);
      rd(5'd1, v); check_eq("wrap_pos", v, 32'hFFFF_FFFF);

      // Asynchronous reset mid-pulse
      rises.delete(); falls.delete();
      bus_wr(5'd2, 32'd3);
      wait_rise(1, 100);
      for (int i = 0; i < 10; i++) tick();
      check_eq("pre_rst_step", {31'b0, step}, 32'd1);
      reset = 1'b0;
      #1;
      check_eq("arst_step", {31'b0, step}, 32'd0);
      check_eq("arst_en", {31'b0, en}, 32'd0);
      rd(5'd0, v); check_eq("arst_status", v, 32'd0);
      rd(5'd1, v); check_eq("arst_pos", v, 32'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 2000; i++) tick();
      check_eq("post_rst_nrise", 32'(rises.size()), 32'd1);
      rd(5'd0, v); check_eq("post_rst_status", v, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chu_stepper.md
# chu_stepper

Step/direction pulse-generator slot core for the FPro MMIO subsystem. It sits directly downstream of the MMIO controller on one slot and drives a stepper-motor driver: pin outputs `step`, `dir` and `en`. Software writes a period and a move command (step count plus direction). The core emits that many evenly spaced step pulses, tracks a signed absolute position, and reports busy/remaining status over the slot read path.

## Interface
- `W`, 24: width of step count and period registers.
- `PULSE_W`, 100: step high time in clk cycles (≥1).
- `SETUP_CYC`, 50: dir-to-first-step setup time in clk cycles (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (one clock domain, no other clocks).
- `cs`  in  1  slot select.
- `read`  in  1  slot read strobe (no side effects).
- `write`  in  1  slot write strobe.
- `addr`  in  5  register index.
- `rd_data`  out  32  combinational read mux.
- `wr_data`  in  32  write data.
- `step`  out  1  step pulse to driver.
- `dir`  out  1  direction, 0 = forward/+1, 1 = reverse/−1.
- `en`  out  1  driver enable, active-high.

## Operation
- A write is accepted on a rising clk edge when `cs & write` is high. Registers by `addr`:
  - 0 CTRL: bit0 = enable.
  - 1 PERIOD: [W-1:0] step period in cycles.
  - 2 MOVE: [W-1:0] = count, bit31 = direction.
  - 3 STOP: any data.
  - 4 POS_CLR: any data.
  - Other addresses are ignored.
- Reads:
  - addr 0 STATUS: bit31 = busy, bit30 = overrun, [W-1:0] = remaining.
  - addr 1 POSITION: 32-bit two's complement.
  - addr 2: PERIOD readback.
  - Others read 0.
- `en` = CTRL.enable.
- Effective period = max(PERIOD, PULSE_W+1).
- FSM states:
  - IDLE: busy=0.
    - MOVE with enable=1 and count≠0: latch count into remaining, latch direction into `dir`, go to SETUP.
    - MOVE with count=0: no action.
    - MOVE with enable=0: ignored.
  - SETUP: wait SETUP_CYC cycles, then go to HIGH.
  - HIGH: `step`=1 for PULSE_W cycles.
    - On entry: remaining −1, position ±1 per `dir`.
    - Then go to LOW.
  - LOW: `step`=0 until effective period cycles have elapsed since the rising edge of `step`.
    - If remaining=0 or stop_pending: go to IDLE.
    - Otherwise go to HIGH.
- busy=1 in SETUP, HIGH and LOW.
- MOVE while busy:
  - The command is ignored.
  - overrun is set (sticky).
- STOP:
  - Sets stop_pending.
  - In SETUP: go to IDLE immediately, with no pulse.
  - In HIGH: the current pulse completes its full PULSE_W, then the full LOW gap runs, then IDLE.
  - In LOW: the current gap completes, then IDLE.
  - Clears remaining to 0 and clears overrun.
  - No effect in IDLE except clearing overrun.
- Clearing enable while busy behaves exactly as STOP. `en` falls on the same edge as the write.
- POS_CLR: position ← 0. If it coincides with a HIGH entry, the clear wins and that step's ±1 is dropped.
- Position wraps modulo 2^32.
- A PERIOD write takes effect at the next HIGH entry.
- `dir` changes only on an accepted MOVE and is held until the next one.

## Timing
- Reset (asynchronous, `reset`=0) values:
  - `step`=0, `dir`=0, `en`=0.
  - PERIOD=0, remaining=0, position=0, overrun=0.
  - FSM=IDLE.
  - `rd_data` reflects these reset values.
- Reset asserted mid-move: `step` drops immediately and no further pulses are issued.
- Accepted MOVE at edge T:
  - `dir` valid and busy=1 from T+1.
  - First `step` rise at edge T+1+SETUP_CYC.
- Successive `step` rising edges are exactly the effective period apart.
- Each high time is exactly PULSE_W cycles.
- busy falls exactly one effective period after the last rising edge of `step`. A MOVE accepted on that same edge is taken.
- STATUS.remaining and POSITION update on the same edge that `step` rises.
- `rd_data` is combinational from `addr` and the registered state: zero read latency.

## Test plan
- Move, forward: PULSE_W=100, SETUP_CYC=50. Write PERIOD=1000, CTRL=1, MOVE=5 forward.
  - Required: 5 pulses, each 100 cycles high.
  - Rising edges 1000 cycles apart; first rise 51 cycles after the write edge.
  - POSITION=5.
  - busy falls 1000 cycles after the 5th rise.
- Move, reverse then sweep:
  - MOVE=3 with bit31=1 after the forward test: `dir`=1, POSITION=2.
  - PERIOD=10 (below PULSE_W+1): rises are 101 cycles apart.
- Boundary cases:
  - MOVE count 0: busy never asserts.
  - MOVE with enable=0: ignored.
  - Second MOVE during a move: ignored, STATUS bit30=1.
  - STOP in IDLE: clears bit30.
- STOP timing:
  - STOP 20 cycles into HIGH of pulse 2 of 10: pulse 2 is full width, no pulse 3, busy falls one period after pulse 2 rise, POSITION=2.
  - STOP during SETUP: zero pulses.
- POS_CLR and wrap:
  - POS_CLR written on the same edge as a step rise: POSITION reads 0.
  - From POSITION=0, a 1-step reverse move: POSITION reads 0xFFFFFFFF.
- Reset during a pulse: `step`, `en`, busy and POSITION read 0 asynchronously. After release, no pulses occur until a new MOVE.
